// File: rtl/seg7_capture.sv
// Receive end of the multiplexed 7-segment bus: samples segments and digit selects,
// waits for each digit to settle, decodes glyphs to BCD and hands out one frame
// per valid/ready handshake. Optional macro SEG7_HEX_EN adds A-F glyph decoding.
module seg7_capture #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [6:0]                seg,
    input  logic [NUM_DIGITS-1:0]     dig_sel,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [4*NUM_DIGITS-1:0]   bcd_out,
    output logic [NUM_DIGITS-1:0]     err_mask
);

    localparam int unsigned SMP_W = NUM_DIGITS + 7;
    localparam int unsigned BCD_W = 4 * NUM_DIGITS;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]      STABLE_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [NUM_DIGITS-1:0] SEL_D0     = NUM_DIGITS'(1);

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_CAPT,
        ST_ADV,
        ST_DONE,
        ST_HOLD
    } state_e;

    state_e                 state_q, state_d;
    logic [SMP_W-1:0]       smp1_q, smp2_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [BCD_W-1:0]       shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]  sh_err_q, sh_err_d;
    logic                   out_valid_q, out_valid_d;
    logic [BCD_W-1:0]       bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]  err_q, err_d;

    logic [6:0]             seg_s;
    logic [NUM_DIGITS-1:0]  sel_s;
    logic [NUM_DIGITS-1:0]  exp_sel;
    logic                   stable;
    logic                   sel_onehot;
    logic                   sel_is_d0;
    logic                   hit;
    logic                   wrong;
    logic                   leave;
    logic                   accept;
    logic [4:0]             dec;

    // Glyph to {err, nibble}; anything unrecognised becomes F with err set.
    function automatic logic [4:0] decode_glyph(input logic [6:0] s);
        logic [4:0] r;
        r = {1'b1, 4'hF};
        case (s)
            7'h3F: r = {1'b0, 4'h0};
            7'h06: r = {1'b0, 4'h1};
            7'h5B: r = {1'b0, 4'h2};
            7'h4F: r = {1'b0, 4'h3};
            7'h66: r = {1'b0, 4'h4};
            7'h6D: r = {1'b0, 4'h5};
            7'h7D: r = {1'b0, 4'h6};
            7'h07: r = {1'b0, 4'h7};
            7'h7F: r = {1'b0, 4'h8};
            7'h6F: r = {1'b0, 4'h9};
`ifdef SEG7_HEX_EN
            7'h77: r = {1'b0, 4'hA};
            7'h7C: r = {1'b0, 4'hB};
            7'h39: r = {1'b0, 4'hC};
            7'h5E: r = {1'b0, 4'hD};
            7'h79: r = {1'b0, 4'hE};
            7'h71: r = {1'b0, 4'hF};
`else
`endif
            default: r = {1'b1, 4'hF};
        endcase
        return r;
    endfunction

    // Two sample flops isolate the asynchronous display source.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            smp1_q <= '0;
            smp2_q <= '0;
            cnt_q  <= '0;
        end else begin
            smp1_q <= {dig_sel, seg};
            smp2_q <= smp1_q;
            cnt_q  <= cnt_d;
        end
    end

    // Run length of identical samples, saturating at STABLE_CYCLES.
    always_comb begin
        cnt_d = cnt_q;
        if (smp1_q != smp2_q) begin
            cnt_d = '0;
        end else if (cnt_q != STABLE_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign seg_s      = smp2_q[6:0];
    assign sel_s      = smp2_q[SMP_W-1:7];
    assign stable     = (cnt_q == STABLE_MAX);
    assign sel_onehot = $onehot(sel_s);
    assign sel_is_d0  = (sel_s == SEL_D0);
    assign exp_sel    = SEL_D0 << idx_q;
    assign hit        = stable && (sel_s == exp_sel);
    assign wrong      = stable && sel_onehot && (sel_s != exp_sel);
    assign leave      = (sel_s != exp_sel);
    assign accept     = out_valid_q && out_ready;
    assign dec        = decode_glyph(seg_s);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SYNC: begin
                if (stable && sel_is_d0) begin
                    state_d = ST_CAPT;
                end
            end
            ST_CAPT: begin
                if (hit) begin
                    state_d = (idx_q == LAST_IDX) ? ST_DONE : ST_ADV;
                end else if (wrong) begin
                    // A stable digit 0 restarts the frame without a detour via SYNC.
                    state_d = sel_is_d0 ? ST_CAPT : ST_SYNC;
                end
            end
            ST_ADV: begin
                if (leave) begin
                    state_d = ST_CAPT;
                end
            end
            ST_DONE: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (accept) begin
                    state_d = ST_SYNC;
                end
            end
            default: begin
                state_d = ST_SYNC;
            end
        endcase
    end

    always_comb begin
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        sh_err_d    = sh_err_q;
        out_valid_d = out_valid_q;
        bcd_d       = bcd_q;
        err_d       = err_q;
        case (state_q)
            ST_SYNC: begin
                idx_d    = '0;
                shadow_d = '0;
                sh_err_d = '0;
            end
            ST_CAPT: begin
                if (hit) begin
                    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            shadow_d[4*i +: 4] = dec[3:0];
                            sh_err_d[i]        = dec[4];
                        end
                    end
                end else if (wrong) begin
                    idx_d    = '0;
                    shadow_d = '0;
                    sh_err_d = '0;
                end
            end
            ST_ADV: begin
                if (leave) begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                bcd_d       = shadow_q;
                err_d       = sh_err_q;
                out_valid_d = 1'b1;
            end
            ST_HOLD: begin
                if (accept) begin
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q       <= '0;
            shadow_q    <= '0;
            sh_err_q    <= '0;
            out_valid_q <= 1'b0;
            bcd_q       <= '0;
            err_q       <= '0;
        end else begin
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            sh_err_q    <= sh_err_d;
            out_valid_q <= out_valid_d;
            bcd_q       <= bcd_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign bcd_out   = bcd_q;
    assign err_mask  = err_q;

    // Structural invariants of the capture engine.
    a_idx_bound: assert property (@(posedge clk) disable iff (!reset_n)
        idx_q <= LAST_IDX);
    a_valid_in_hold: assert property (@(posedge clk) disable iff (!reset_n)
        out_valid_q |-> (state_q == ST_HOLD));

endmodule

// File: tb/tb_seg7_capture.sv
// Scoreboard bench for seg7_capture: directed frames push expected results,
// a negedge monitor compares every presented frame and the post-accept drop.
module tb_seg7_capture;

    localparam int unsigned ND = 4;
    localparam int unsigned SC = 4;

    typedef struct packed {
        logic [15:0] bcd;
        logic [3:0]  err;
    } frame_t;

    logic          clk;
    logic          reset_n;
    logic [6:0]    seg;
    logic [ND-1:0] dig_sel;
    logic          out_ready;
    logic          out_valid;
    logic [15:0]   bcd_out;
    logic [ND-1:0] err_mask;

    int     checks;
    int     errors;
    int     frames_seen;
    logic   accept_prev;
    frame_t sb_q[$];
    frame_t exp_f;

    seg7_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .seg       (seg),
        .dig_sel   (dig_sel),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .bcd_out   (bcd_out),
        .err_mask  (err_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input int v);
        logic [6:0] g;
        case (v)
            0: g = 7'h3F;  1: g = 7'h06;  2: g = 7'h5B;  3: g = 7'h4F;
            4: g = 7'h66;  5: g = 7'h6D;  6: g = 7'h7D;  7: g = 7'h07;
            8: g = 7'h7F;  9: g = 7'h6F;
            default: g = 7'h00;
        endcase
        return g;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic show(input int d, input logic [6:0] g, input int n);
        dig_sel = ND'(1) << d;
        seg     = g;
        wait_clks(n);
    endtask

    task automatic idle(input int n);
        dig_sel = '0;
        seg     = 7'h00;
        wait_clks(n);
    endtask

    task automatic send_frame(input logic [6:0] g0, input logic [6:0] g1,
                              input logic [6:0] g2, input logic [6:0] g3, input int hold);
        show(0, g0, hold);
        show(1, g1, hold);
        show(2, g2, hold);
        show(3, g3, hold);
    endtask

    task automatic expect_frame(input logic [15:0] b, input logic [3:0] e);
        frame_t f;
        f.bcd = b;
        f.err = e;
        sb_q.push_back(f);
    endtask

    task automatic wait_valid(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (out_valid) break;
            wait_clks(1);
        end
        check("wait_valid", 32'(out_valid), 32'd1);
    endtask

    // Monitor: compares every presented frame, pops on handshake, checks the drop.
    always @(negedge clk) begin
        if (accept_prev) begin
            accept_prev = 1'b0;
            checks++;
            if (out_valid) begin
                errors++;
                $display("FAIL valid_drop: out_valid still 1 one clk after accept at %0t", $time);
            end
        end
        if (reset_n && out_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_frame: bcd %h err %b with nothing expected at %0t",
                         bcd_out, err_mask, $time);
            end else begin
                exp_f = sb_q[0];
                if (bcd_out !== exp_f.bcd) begin
                    errors++;
                    $display("FAIL frame_bcd: got %h expected %h at %0t", bcd_out, exp_f.bcd, $time);
                end
                checks++;
                if (err_mask !== exp_f.err) begin
                    errors++;
                    $display("FAIL frame_err: got %b expected %b at %0t", err_mask, exp_f.err, $time);
                end
                if (out_ready) begin
                    void'(sb_q.pop_front());
                    frames_seen++;
                    accept_prev = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks      = 0;
        errors      = 0;
        frames_seen = 0;
        accept_prev = 1'b0;
        reset_n     = 1'b0;
        seg         = 7'h00;
        dig_sel     = '0;
        out_ready   = 1'b1;
        #1;
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_bcd", 32'(bcd_out), 32'd0);
        check("reset_err", 32'(err_mask), 32'd0);
        wait_clks(3);
        reset_n = 1'b1;
        idle(5);

        // 1: clean frame, consumer always ready.
        expect_frame(16'h4321, 4'b0000);
        send_frame(glyph(1), glyph(2), glyph(3), glyph(4), 8);
        idle(10);
        check("t1_drained", 32'(sb_q.size()), 32'd0);
        check("t1_frames", 32'(frames_seen), 32'd1);

        // 2: consumer stalls 20 clk; a frame shown during the stall is ignored.
        out_ready = 1'b0;
        expect_frame(16'h4321, 4'b0000);
        send_frame(glyph(1), glyph(2), glyph(3), glyph(4), 8);
        wait_valid(20);
        show(0, glyph(9), 8);
        show(1, glyph(9), 8);
        show(2, glyph(9), 4);
        check("t2_held", 32'(out_valid), 32'd1);
        check("t2_frozen", 32'(bcd_out), 32'h4321);
        out_ready = 1'b1;
        wait_clks(4);
        show(3, glyph(9), 8);
        idle(10);
        check("t2_drained", 32'(sb_q.size()), 32'd0);
        check("t2_frames", 32'(frames_seen), 32'd2);

        // 3: blank digit 2 then hex glyph A on digit 2.
        expect_frame(16'h4F21, 4'b0100);
        send_frame(glyph(1), glyph(2), 7'h00, glyph(4), 8);
        idle(10);
`ifdef SEG7_HEX_EN
        expect_frame(16'h4A21, 4'b0000);
`else
        expect_frame(16'h4F21, 4'b0100);
`endif
        send_frame(glyph(1), glyph(2), 7'h77, glyph(4), 8);
        idle(10);
        check("t3_drained", 32'(sb_q.size()), 32'd0);
        check("t3_frames", 32'(frames_seen), 32'd4);

        // 4: digits too short to settle produce nothing.
        send_frame(glyph(1), glyph(2), glyph(3), glyph(4), SC - 1);
        send_frame(glyph(5), glyph(6), glyph(7), glyph(8), SC - 1);
        idle(10);
        check("t4_valid", 32'(out_valid), 32'd0);
        check("t4_frames", 32'(frames_seen), 32'd4);

        // 5: out-of-order scan d0,d1,d3 is discarded; the following clean frame lands.
        show(0, glyph(1), 8);
        show(1, glyph(2), 8);
        show(3, glyph(4), 8);
        expect_frame(16'h8765, 4'b0000);
        send_frame(glyph(5), glyph(6), glyph(7), glyph(8), 8);
        idle(10);
        check("t5_drained", 32'(sb_q.size()), 32'd0);
        check("t5_frames", 32'(frames_seen), 32'd5);
        check("t5_bcd_kept", 32'(bcd_out), 32'h8765);

        // 6: asynchronous reset mid-frame clears outputs at once.
        show(0, glyph(1), 8);
        show(1, glyph(2), 8);
        dig_sel = 4'b0100;
        seg     = glyph(3);
        wait_clks(2);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_bcd", 32'(bcd_out), 32'd0);
        check("t6_rst_err", 32'(err_mask), 32'd0);
        wait_clks(2);
        reset_n = 1'b1;
        show(2, glyph(3), 6);
        show(3, glyph(4), 8);
        idle(5);
        check("t6_no_frame", 32'(frames_seen), 32'd5);
        expect_frame(16'h7309, 4'b0000);
        send_frame(glyph(9), glyph(0), glyph(3), glyph(7), 8);
        idle(10);
        check("t6_drained", 32'(sb_q.size()), 32'd0);
        check("t6_frames", 32'(frames_seen), 32'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
